// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared register-file constants and types for the core writeback path
package core_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_EX   = 2'd1,
      GNT_LSU  = 2'd2
   } gnt_e;
endpackage

// File: rtl/core_reg_sb.sv
// rtl/core_reg_sb.sv - load scoreboard: busy bit per register, set/clear and 3-way hazard lookup
module core_reg_sb
   import core_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       set_en,
   input  reg_addr_t                  set_addr,
   input  logic                       clr_en,
   input  reg_addr_t                  clr_addr,
   input  logic [2:0][REG_ADDR_W-1:0] look_addr,
   output logic [2:0]                 look_hz
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_en && clr_addr != REG_ZERO) busy_d[clr_addr] = 1'b0;
      // set is applied last so a same-cycle set/clear leaves the register busy
      if (set_en && set_addr != REG_ZERO) busy_d[set_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   // a register whose load data is being written this cycle is covered by bypass
   always_comb begin
      look_hz = '0;
      for (int i = 0; i < 3; i++) begin
         look_hz[i] = (look_addr[i] != REG_ZERO) && busy_q[look_addr[i]] &&
                      !(clr_en && clr_addr == look_addr[i]);
      end
   end

endmodule

// File: rtl/core_reg_wbctrl.sv
// rtl/core_reg_wbctrl.sv - regfile write-port arbiter (EX/LSU), load stall and read bypass
module core_reg_wbctrl
   import core_pkg::*;
#(
   parameter int XLEN        = core_pkg::XLEN,
   parameter int EX_MAX_WAIT = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            ISSUE_VALID,
   input  logic [4:0]      ISSUE_RS1ADDR,
   input  logic [4:0]      ISSUE_RS2ADDR,
   input  logic [4:0]      ISSUE_RDADDR,
   input  logic            ISSUE_IS_LOAD,
   output logic            ISSUE_STALL,
   input  logic            EX_WB_VALID,
   input  logic [4:0]      EX_WB_ADDR,
   input  logic [XLEN-1:0] EX_WB_DATA,
   output logic            EX_WB_READY,
   input  logic            LSU_WB_VALID,
   input  logic [4:0]      LSU_WB_ADDR,
   input  logic [XLEN-1:0] LSU_WB_DATA,
   output logic            LSU_WB_READY,
   output logic            WE,
   output logic [4:0]      WADDR,
   output logic [XLEN-1:0] WDATA,
   output logic            RS1_BYP_VALID,
   output logic [XLEN-1:0] RS1_BYP_DATA,
   output logic            RS2_BYP_VALID,
   output logic [XLEN-1:0] RS2_BYP_DATA
);

   localparam logic [3:0] MAX_WAIT = 4'(EX_MAX_WAIT);

   gnt_e            gnt;
   logic            lsu_we;
   logic            issue_fire;
   logic [2:0]      hz;
   logic [3:0]      starve_q, starve_d;
   logic            rs1_byp_valid_q, rs1_byp_valid_d;
   logic            rs2_byp_valid_q, rs2_byp_valid_d;
   logic [XLEN-1:0] rs1_byp_data_q, rs1_byp_data_d;
   logic [XLEN-1:0] rs2_byp_data_q, rs2_byp_data_d;

   always_comb begin
      gnt = GNT_NONE;
      if (EX_WB_VALID && (!LSU_WB_VALID || starve_q == MAX_WAIT)) gnt = GNT_EX;
      else if (LSU_WB_VALID)                                      gnt = GNT_LSU;

      EX_WB_READY  = (gnt == GNT_EX);
      LSU_WB_READY = (gnt == GNT_LSU);
      WADDR        = (gnt == GNT_EX) ? EX_WB_ADDR : LSU_WB_ADDR;
      WDATA        = (gnt == GNT_EX) ? EX_WB_DATA : LSU_WB_DATA;
      // x0 requests are accepted and dropped; nothing is written while in reset
      WE           = (gnt != GNT_NONE) && (WADDR != REG_ZERO) && !RST;
      lsu_we       = (gnt == GNT_LSU) && WE;
   end

   always_comb begin
      starve_d = starve_q;
      if (!EX_WB_VALID || gnt == GNT_EX) starve_d = 4'd0;
      else if (starve_q != MAX_WAIT)     starve_d = starve_q + 4'd1;
   end

   core_reg_sb u_sb (
      .clk       (CLK),
      .rst       (RST),
      .set_en    (issue_fire && ISSUE_IS_LOAD),
      .set_addr  (ISSUE_RDADDR),
      .clr_en    (lsu_we),
      .clr_addr  (LSU_WB_ADDR),
      .look_addr ({ISSUE_RDADDR, ISSUE_RS2ADDR, ISSUE_RS1ADDR}),
      .look_hz   (hz)
   );

   always_comb begin
      ISSUE_STALL = ISSUE_VALID && (|hz);
      issue_fire  = ISSUE_VALID && !ISSUE_STALL;
   end

   // the regfile returns the old value on a same-cycle collision, so capture the write
   always_comb begin
      rs1_byp_valid_d = WE && (WADDR == ISSUE_RS1ADDR);
      rs2_byp_valid_d = WE && (WADDR == ISSUE_RS2ADDR);
      rs1_byp_data_d  = rs1_byp_valid_d ? WDATA : rs1_byp_data_q;
      rs2_byp_data_d  = rs2_byp_valid_d ? WDATA : rs2_byp_data_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_q        <= 4'd0;
         rs1_byp_valid_q <= 1'b0;
         rs2_byp_valid_q <= 1'b0;
         rs1_byp_data_q  <= '0;
         rs2_byp_data_q  <= '0;
      end else begin
         starve_q        <= starve_d;
         rs1_byp_valid_q <= rs1_byp_valid_d;
         rs2_byp_valid_q <= rs2_byp_valid_d;
         rs1_byp_data_q  <= rs1_byp_data_d;
         rs2_byp_data_q  <= rs2_byp_data_d;
      end
   end

   assign RS1_BYP_VALID = rs1_byp_valid_q;
   assign RS1_BYP_DATA  = rs1_byp_data_q;
   assign RS2_BYP_VALID = rs2_byp_valid_q;
   assign RS2_BYP_DATA  = rs2_byp_data_q;

endmodule

// File: tb/tb_core_reg_wbctrl.sv
// tb/tb_core_reg_wbctrl.sv - self-checking bench for core_reg_wbctrl with a write scoreboard
module tb_core_reg_wbctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ISSUE_VALID;
   logic [4:0]  ISSUE_RS1ADDR, ISSUE_RS2ADDR, ISSUE_RDADDR;
   logic        ISSUE_IS_LOAD;
   logic        ISSUE_STALL;
   logic        EX_WB_VALID;
   logic [4:0]  EX_WB_ADDR;
   logic [31:0] EX_WB_DATA;
   logic        EX_WB_READY;
   logic        LSU_WB_VALID;
   logic [4:0]  LSU_WB_ADDR;
   logic [31:0] LSU_WB_DATA;
   logic        LSU_WB_READY;
   logic        WE;
   logic [4:0]  WADDR;
   logic [31:0] WDATA;
   logic        RS1_BYP_VALID, RS2_BYP_VALID;
   logic [31:0] RS1_BYP_DATA, RS2_BYP_DATA;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   core_reg_wbctrl #(.XLEN(32), .EX_MAX_WAIT(4)) dut (
      .CLK(CLK), .RST(RST),
      .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1ADDR(ISSUE_RS1ADDR), .ISSUE_RS2ADDR(ISSUE_RS2ADDR),
      .ISSUE_RDADDR(ISSUE_RDADDR), .ISSUE_IS_LOAD(ISSUE_IS_LOAD), .ISSUE_STALL(ISSUE_STALL),
      .EX_WB_VALID(EX_WB_VALID), .EX_WB_ADDR(EX_WB_ADDR), .EX_WB_DATA(EX_WB_DATA),
      .EX_WB_READY(EX_WB_READY),
      .LSU_WB_VALID(LSU_WB_VALID), .LSU_WB_ADDR(LSU_WB_ADDR), .LSU_WB_DATA(LSU_WB_DATA),
      .LSU_WB_READY(LSU_WB_READY),
      .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
      .RS1_BYP_VALID(RS1_BYP_VALID), .RS1_BYP_DATA(RS1_BYP_DATA),
      .RS2_BYP_VALID(RS2_BYP_VALID), .RS2_BYP_DATA(RS2_BYP_DATA)
   );

   always #5 CLK = ~CLK;

   // every regfile write must match the oldest expected write
   always @(negedge CLK) begin
      if (WE === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", WADDR, WDATA);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (WADDR !== e.addr || WDATA !== e.data) begin
               errors++;
               $display("FAIL wr_match: got addr=%0d data=%h, required addr=%0d data=%h",
                        WADDR, WDATA, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ISSUE_VALID = 0; ISSUE_RS1ADDR = 0; ISSUE_RS2ADDR = 0; ISSUE_RDADDR = 0; ISSUE_IS_LOAD = 0;
      EX_WB_VALID = 0; EX_WB_ADDR = 0; EX_WB_DATA = 0;
      LSU_WB_VALID = 0; LSU_WB_ADDR = 0; LSU_WB_DATA = 0;
   endtask

   task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      idle();
      RST = 1;
      next_cycle();
      next_cycle();
      @(negedge CLK);
      checks++;
      if ({WE, EX_WB_READY, LSU_WB_READY, ISSUE_STALL} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_comb: got we/exr/lsur/stall=%b, required 0000",
                  {WE, EX_WB_READY, LSU_WB_READY, ISSUE_STALL});
      end
      checks++;
      if (RS1_BYP_VALID !== 0 || RS2_BYP_VALID !== 0 || RS1_BYP_DATA !== 0 || RS2_BYP_DATA !== 0) begin
         errors++;
         $display("FAIL reset_byp: got v1=%b v2=%b d1=%h d2=%h, required all 0",
                  RS1_BYP_VALID, RS2_BYP_VALID, RS1_BYP_DATA, RS2_BYP_DATA);
      end
      next_cycle();
      RST = 0;
   endtask

   task automatic test_ex_only();
      EX_WB_VALID = 1; EX_WB_ADDR = 5; EX_WB_DATA = 32'h1234;
      ISSUE_RS1ADDR = 5;
      push_wr(5, 32'h1234);
      @(negedge CLK);
      checks++;
      if (EX_WB_READY !== 1 || WE !== 1 || WADDR !== 5 || WDATA !== 32'h1234 || LSU_WB_READY !== 0) begin
         errors++;
         $display("FAIL ex_only: got exr=%b we=%b waddr=%0d wdata=%h lsur=%b, required 1 1 5 00001234 0",
                  EX_WB_READY, WE, WADDR, WDATA, LSU_WB_READY);
      end
      next_cycle();
      EX_WB_VALID = 0;
      @(negedge CLK);
      checks++;
      if (RS1_BYP_VALID !== 1 || RS1_BYP_DATA !== 32'h1234 || RS2_BYP_VALID !== 0) begin
         errors++;
         $display("FAIL ex_bypass: got v1=%b d1=%h v2=%b, required 1 00001234 0",
                  RS1_BYP_VALID, RS1_BYP_DATA, RS2_BYP_VALID);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_starvation();
      logic exp_ex;
      EX_WB_VALID = 1; EX_WB_ADDR = 3; EX_WB_DATA = 32'hAAAA0003;
      LSU_WB_VALID = 1; LSU_WB_ADDR = 4; LSU_WB_DATA = 32'hBBBB0004;
      for (int i = 0; i < 6; i++) begin
         // cycles 0-3 LSU, cycle 4 EX forced, cycle 5 counter cleared so LSU again
         exp_ex = (i == 4);
         if (exp_ex) push_wr(3, 32'hAAAA0003);
         else        push_wr(4, 32'hBBBB0004);
         @(negedge CLK);
         checks++;
         if (EX_WB_READY !== exp_ex || LSU_WB_READY !== !exp_ex) begin
            errors++;
            $display("FAIL starve_cyc%0d: got exr=%b lsur=%b, required exr=%b lsur=%b",
                     i, EX_WB_READY, LSU_WB_READY, exp_ex, !exp_ex);
         end
         next_cycle();
      end
      idle();
   endtask

   task automatic test_load_raw();
      ISSUE_VALID = 1; ISSUE_RDADDR = 7; ISSUE_IS_LOAD = 1;
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 0) begin
         errors++;
         $display("FAIL raw_load_issue: got stall=%b, required 0", ISSUE_STALL);
      end
      next_cycle();
      ISSUE_RDADDR = 0; ISSUE_IS_LOAD = 0; ISSUE_RS1ADDR = 7;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         checks++;
         if (ISSUE_STALL !== 1) begin
            errors++;
            $display("FAIL raw_stall%0d: got stall=%b, required 1", i, ISSUE_STALL);
         end
         next_cycle();
      end
      LSU_WB_VALID = 1; LSU_WB_ADDR = 7; LSU_WB_DATA = 32'hDEADBEEF;
      push_wr(7, 32'hDEADBEEF);
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 0 || LSU_WB_READY !== 1) begin
         errors++;
         $display("FAIL raw_commit: got stall=%b lsur=%b, required 0 1", ISSUE_STALL, LSU_WB_READY);
      end
      next_cycle();
      LSU_WB_VALID = 0; ISSUE_VALID = 0;
      @(negedge CLK);
      checks++;
      if (RS1_BYP_VALID !== 1 || RS1_BYP_DATA !== 32'hDEADBEEF || RS2_BYP_VALID !== 0) begin
         errors++;
         $display("FAIL raw_bypass: got v1=%b d1=%h v2=%b, required 1 deadbeef 0",
                  RS1_BYP_VALID, RS1_BYP_DATA, RS2_BYP_VALID);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_set_clear_same();
      ISSUE_VALID = 1; ISSUE_RDADDR = 9; ISSUE_IS_LOAD = 1;
      next_cycle();
      LSU_WB_VALID = 1; LSU_WB_ADDR = 9; LSU_WB_DATA = 32'h00000009;
      push_wr(9, 32'h00000009);
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 0) begin
         errors++;
         $display("FAIL setclr_nostall: got stall=%b, required 0", ISSUE_STALL);
      end
      next_cycle();
      LSU_WB_VALID = 0; ISSUE_IS_LOAD = 0; ISSUE_RDADDR = 0; ISSUE_RS1ADDR = 9;
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 1) begin
         errors++;
         $display("FAIL setclr_busy: got stall=%b, required 1", ISSUE_STALL);
      end
      next_cycle();
      ISSUE_VALID = 0;
      LSU_WB_VALID = 1; LSU_WB_DATA = 32'h00000099;
      push_wr(9, 32'h00000099);
      next_cycle();
      idle();
      ISSUE_VALID = 1; ISSUE_RS1ADDR = 9;
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 0) begin
         errors++;
         $display("FAIL setclr_cleared: got stall=%b, required 0", ISSUE_STALL);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_zero_addr();
      EX_WB_VALID = 1; EX_WB_ADDR = 0; EX_WB_DATA = 32'hFFFFFFFF;
      ISSUE_VALID = 1; ISSUE_RS1ADDR = 0; ISSUE_RS2ADDR = 0; ISSUE_RDADDR = 0;
      @(negedge CLK);
      checks++;
      if (EX_WB_READY !== 1 || WE !== 0 || ISSUE_STALL !== 0) begin
         errors++;
         $display("FAIL zero_addr: got exr=%b we=%b stall=%b, required 1 0 0",
                  EX_WB_READY, WE, ISSUE_STALL);
      end
      next_cycle();
      EX_WB_VALID = 0; ISSUE_VALID = 0;
      @(negedge CLK);
      checks++;
      if (RS1_BYP_VALID !== 0 || RS2_BYP_VALID !== 0) begin
         errors++;
         $display("FAIL zero_bypass: got v1=%b v2=%b, required 0 0", RS1_BYP_VALID, RS2_BYP_VALID);
      end
      next_cycle();
      idle();
   endtask

   task automatic test_reset_mid();
      ISSUE_VALID = 1; ISSUE_IS_LOAD = 1; ISSUE_RDADDR = 2;
      next_cycle();
      ISSUE_RDADDR = 6;
      next_cycle();
      ISSUE_IS_LOAD = 0; ISSUE_RDADDR = 0; ISSUE_RS1ADDR = 2; ISSUE_RS2ADDR = 6;
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 1) begin
         errors++;
         $display("FAIL rstmid_pre: got stall=%b, required 1", ISSUE_STALL);
      end
      next_cycle();
      ISSUE_VALID = 0;
      LSU_WB_VALID = 1; LSU_WB_ADDR = 2; LSU_WB_DATA = 32'h22222222;
      RST = 1;
      @(negedge CLK);
      checks++;
      if (WE !== 0) begin
         errors++;
         $display("FAIL rstmid_we: got we=%b, required 0", WE);
      end
      next_cycle();
      RST = 0;
      LSU_WB_VALID = 0;
      ISSUE_VALID = 1; ISSUE_RS1ADDR = 2; ISSUE_RS2ADDR = 6;
      @(negedge CLK);
      checks++;
      if (ISSUE_STALL !== 0 || RS1_BYP_VALID !== 0 || RS2_BYP_VALID !== 0 || RS1_BYP_DATA !== 0) begin
         errors++;
         $display("FAIL rstmid_post: got stall=%b v1=%b v2=%b d1=%h, required 0 0 0 0",
                  ISSUE_STALL, RS1_BYP_VALID, RS2_BYP_VALID, RS1_BYP_DATA);
      end
      next_cycle();
      idle();
   endtask

   initial begin
      test_reset();
      test_ex_only();
      test_starvation();
      test_load_raw();
      test_set_clear_same();
      test_zero_addr();
      test_reset_mid();
      next_cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wr_pending: got %0d writes still expected, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
